// File: rtl/adc_scan_ctrl.sv
// Round-robin scan sequencer for an ADC0809-class converter: drives the
// START/ALE/OE handshake, captures each result and flags lost EOCs.
module adc_scan_ctrl #(
  parameter int CLK_DIV     = 16,
  parameter int NUM_CH      = 4,
  parameter int START_CYC   = 2,
  parameter int OE_CYC      = 2,
  parameter int EOC_TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scan_en,
  input  logic       err_clr,
  input  logic       adc_eoc,
  input  logic [7:0] adc_data,
  output logic       adc_clk,
  output logic [2:0] adc_addr,
  output logic       adc_ale,
  output logic       adc_start,
  output logic       adc_oe,
  output logic [7:0] p0_out,
  output logic [2:0] sample_ch,
  output logic       sample_valid,
  output logic       timeout_err
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PH_MAX = (START_CYC > OE_CYC) ? START_CYC : OE_CYC;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int TMO_W  = $clog2(EOC_TIMEOUT + 1);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]  START_LAST = PH_W'(START_CYC - 1);
  localparam logic [PH_W-1:0]  OE_LAST    = PH_W'(OE_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(EOC_TIMEOUT - 1);
  localparam logic [2:0]       CH_LAST    = 3'(NUM_CH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_START, S_WAIT_LO, S_WAIT_HI, S_READ, S_NEXT
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [PH_W-1:0]  phase_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [2:0]       ch;
  logic             eoc_meta;
  logic             eoc_s;
  logic             in_wait;
  logic             tmo_hit;

  assign adc_addr = ch;
  assign in_wait  = (state == S_WAIT_LO) || (state == S_WAIT_HI);
  // Fires on the EOC_TIMEOUT-th cycle spent across both wait states.
  assign tmo_hit  = in_wait && (tmo_cnt == TMO_LAST);

  // Free-running converter clock, independent of the sequencer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      adc_clk <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      adc_clk <= ~adc_clk;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // NOTE: non-blocking assignments make eoc_s take eoc_meta's old value, giving two real flop stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eoc_meta <= 1'b0;
      eoc_s    <= 1'b0;
    end else begin
      eoc_meta <= adc_eoc;
      eoc_s    <= eoc_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      ch           <= '0;
      phase_cnt    <= '0;
      tmo_cnt      <= '0;
      adc_ale      <= 1'b0;
      adc_start    <= 1'b0;
      adc_oe       <= 1'b0;
      p0_out       <= '0;
      sample_ch    <= '0;
      sample_valid <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      // NOTE: default-then-override keeps sample_valid a single-cycle strobe without per-state clears.
      sample_valid <= 1'b0;

      if (tmo_hit)      timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;

      case (state)
        S_IDLE: if (scan_en) state <= S_ADDR;
        S_ADDR: begin
          adc_ale   <= 1'b1;
          adc_start <= 1'b1;
          phase_cnt <= '0;
          state     <= S_START;
        end
        S_START: begin
          if (phase_cnt == START_LAST) begin
            adc_ale   <= 1'b0;
            adc_start <= 1'b0;
            tmo_cnt   <= '0;
            state     <= S_WAIT_LO;
          end else begin
            phase_cnt <= phase_cnt + PH_W'(1);
          end
        end
        S_WAIT_LO: begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
          if (tmo_hit)     state <= S_NEXT;
          else if (!eoc_s) state <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
          if (tmo_hit) begin
            state <= S_NEXT;
          end else if (eoc_s) begin
            adc_oe    <= 1'b1;
            phase_cnt <= '0;
            state     <= S_READ;
          end
        end
        S_READ: begin
          if (phase_cnt == OE_LAST) begin
            adc_oe       <= 1'b0;
            p0_out       <= adc_data;
            sample_ch    <= ch;
            sample_valid <= 1'b1;
            state        <= S_NEXT;
          end else begin
            phase_cnt <= phase_cnt + PH_W'(1);
          end
        end
        S_NEXT: begin
          ch    <= (ch == CH_LAST) ? 3'd0 : ch + 3'd1;
          state <= scan_en ? S_ADDR : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/adc_scan_ctrl.md
Name: adc_scan_ctrl

Overview:
Sequencer for an ADC0809-class 8-bit parallel ADC. It scans analog channels round-robin, handshakes START/ALE/EOC/OE, and captures each conversion result. Output p0_out drives the p0_in bus of the downstream 8-stage XRAM delay line, which aligns the sample with the 8051 external-RAM write timing. It also flags conversions whose EOC never arrives.

Parameters:
CLK_DIV, 16, clk cycles per adc_clk half-period (≥1)
NUM_CH, 4, channels scanned, 1..8
START_CYC, 2, clk cycles adc_start/adc_ale held high (≥1)
OE_CYC, 2, clk cycles adc_oe held high before capture (≥1)
EOC_TIMEOUT, 1023, max clk cycles in EOC wait states before abort (≥4)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
scan_en  in  1  level: run continuous scan
err_clr  in  1  pulse: clear timeout_err
adc_eoc  in  1  ADC end-of-conversion, asynchronous to clk
adc_data  in  8  ADC tri-state data bus, valid while adc_oe high
adc_clk  out  1  ADC conversion clock
adc_addr  out  3  ADC mux address
adc_ale  out  1  address latch enable
adc_start  out  1  conversion start
adc_oe  out  1  ADC output enable
p0_out  out  8  last captured sample (to delay line p0_in)
sample_ch  out  3  channel of p0_out
sample_valid  out  1  one-cycle strobe: new p0_out
timeout_err  out  1  sticky EOC timeout flag

Behaviour:
- Reset (async, immediate, also mid-conversion): all outputs 0, channel counter 0, FSM IDLE, divider 0, synchroniser flops 0.
- adc_clk: free-running after reset; toggles when the divider reaches CLK_DIV-1, so the period is 2*CLK_DIV clk cycles. It is independent of FSM state.
- adc_eoc passes through a 2-flop synchroniser (eoc_s). All FSM decisions use eoc_s, which adds 2 cycles of latency.
- adc_addr = channel counter at all times. It changes only in NEXT or on reset.
- FSM states:
  - IDLE: all strobes low. Go to ADDR when scan_en=1.
  - ADDR: 1 cycle of address setup. Go to START.
  - START: adc_ale=adc_start=1 for exactly START_CYC cycles. Go to WAIT_LO and clear the timeout counter.
  - WAIT_LO: wait for eoc_s=0 (conversion began). Go to WAIT_HI.
  - WAIT_HI: wait for eoc_s=1. Go to READ.
  - Timeout: the counter increments every cycle in WAIT_LO and WAIT_HI and is not cleared between them. When the count reaches EOC_TIMEOUT, set timeout_err and go to NEXT. In that case there is no capture and p0_out, sample_ch and sample_valid are unchanged.
  - READ: adc_oe=1 for OE_CYC cycles. On the clock edge ending the last READ cycle, p0_out<=adc_data, sample_ch<=channel and sample_valid<=1. Go to NEXT.
  - NEXT: 1 cycle. sample_valid is high during this cycle only. The channel counter increments; at NUM_CH-1 it wraps to 0. Go to ADDR if scan_en=1, else IDLE.
- scan_en deasserted mid-conversion: the current conversion completes, including capture, then the FSM returns to IDLE. The next scan resumes at the following channel.
- NUM_CH=1: adc_addr stays 0 permanently.
- timeout_err: set has priority over err_clr in the same cycle. Otherwise err_clr clears it on the next edge.
- Nominal conversion latency from entering ADDR to sample_valid = 1+START_CYC+(WAIT cycles)+OE_CYC.
- The block never drives adc_data. It has no backpressure: the consumer must accept sample_valid every cycle it is asserted.

Test Plan:
- Basic scan, with CLK_DIV=4, NUM_CH=4, START_CYC=2, OE_CYC=2, EOC_TIMEOUT=64. Stimulus: ADC model drops EOC 3 cycles after start and raises it 20 cycles later with data=0x10+ch. Required: p0_out sequence 0x10, 0x11, 0x12, 0x13, 0x10 and sample_ch 0,1,2,3,0, one sample_valid pulse each. adc_clk period is 8 cycles.
- Handshake timing. Required: adc_start/adc_ale high for exactly 2 cycles after a 1-cycle ADDR. adc_oe high exactly 2 cycles. p0_out is unchanged before the strobe. adc_addr is stable from ADDR through READ.
- EOC stuck high. Required: timeout_err=1 at 64 cycles after START ends. No sample_valid and p0_out held. The scan advances to the next channel. Asserting err_clr then clears the flag.
- Simultaneous set/clear: err_clr=1 on the cycle the timeout fires. Required: timeout_err stays 1.
- Drop scan_en during WAIT_HI on ch2 (data 0xA5). Required: capture 0xA5 with sample_ch=2, then IDLE. Re-enable and the next conversion is on ch3.
- Assert rst_n=0 during READ. Required: all outputs 0 immediately, adc_oe released the same cycle, and the restart begins on ch0.
